// File: rtl/sensor_config_seq.sv
// sensor_config_seq
// Walks a synchronous configuration ROM and turns each entry into a register
// write on an external serial bus (I2C/SPI style master). Entries are
// {reg, data}. reg = all-ones marks special entries: data = all-ones ends
// the sequence, any other data value is a delay in units of DELAY_US.
// Writes that NACK or time out are re-issued up to MAX_RETRY times before
// the sequence gives up and reports the failing ROM address.

module sensor_config_seq #(
    parameter int CLK_FREQ    = 25000000,
    parameter int ADDR_W      = 8,
    parameter int REG_W       = 8,
    parameter int DATA_W      = 8,
    parameter int MAX_RETRY   = 3,
    parameter int TIMEOUT_CYC = 100000,
    parameter int DELAY_US    = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    output logic [ADDR_W-1:0]       rom_addr,
    input  logic [REG_W+DATA_W-1:0] rom_data,
    input  logic                    bus_ready,
    output logic                    bus_start,
    output logic [REG_W-1:0]        bus_reg,
    output logic [DATA_W-1:0]       bus_data,
    input  logic                    bus_done,
    input  logic                    bus_nack,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [ADDR_W-1:0]       err_addr
);

    // Clock cycles in one delay unit, and the longest delay a single entry
    // can request (data = all-ones minus one, rounded up to all-ones here).
    localparam longint CYC_PER_UNIT = longint'(CLK_FREQ / 1000000) * longint'(DELAY_US);
    localparam longint MAX_DELAY    = ((longint'(1) << DATA_W) - 1) * CYC_PER_UNIT;
    localparam int     DELAY_W      = (MAX_DELAY > 1) ? $clog2(MAX_DELAY + 1) : 1;

    // The timeout counter only needs to reach TIMEOUT_CYC-1.
    localparam int     TMO_W        = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int     RETRY_W      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [DELAY_W-1:0] UNIT_CYC  = DELAY_W'(CYC_PER_UNIT);
    localparam logic [DELAY_W-1:0] DELAY_ONE = DELAY_W'(1);
    localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [TMO_W-1:0]   TMO_ONE   = TMO_W'(1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
    localparam logic [RETRY_W-1:0] RETRY_ONE = RETRY_W'(1);
    localparam logic [ADDR_W-1:0]  ADDR_ONE  = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_WAIT_ACK,
        S_DELAY,
        S_DONE,
        S_ERROR
    } state_t;

    state_t             state;
    logic [RETRY_W-1:0] retry_cnt;
    logic [TMO_W-1:0]   timeout_cnt;
    logic [DELAY_W-1:0] delay_cnt;

    logic [REG_W-1:0]   entry_reg;
    logic [DATA_W-1:0]  entry_data;
    logic               reg_is_special;
    logic               data_is_end;
    logic               addr_is_last;

    // Split the ROM word and flag the special encodings used by DECODE.
    assign entry_reg      = rom_data[REG_W+DATA_W-1:DATA_W];
    assign entry_data     = rom_data[DATA_W-1:0];
    assign reg_is_special = &entry_reg;
    assign data_is_end    = &entry_data;
    assign addr_is_last   = &rom_addr;

    // Busy is a pure decode of the state register, so it drops together with
    // the state returning to IDLE (including on asynchronous reset).
    assign busy = (state != S_IDLE);

    // Sequencer: one registered FSM owning every output and counter. Abort is
    // checked ahead of the state decode so it wins over start and bus_done.
    // Stepping past the last ROM address stops in ERROR with rom_addr left at
    // all-ones, which is exactly what err_addr then reports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            rom_addr    <= '0;
            bus_start   <= 1'b0;
            bus_reg     <= '0;
            bus_data    <= '0;
            done        <= 1'b0;
            error       <= 1'b0;
            err_addr    <= '0;
            retry_cnt   <= '0;
            timeout_cnt <= '0;
            delay_cnt   <= '0;
        end else if (abort) begin
            state     <= S_IDLE;
            bus_start <= 1'b0;
        end else begin
            bus_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        rom_addr  <= '0;
                        retry_cnt <= '0;
                        done      <= 1'b0;
                        error     <= 1'b0;
                        state     <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    state <= S_DECODE;
                end

                S_DECODE: begin
                    if (reg_is_special) begin
                        if (data_is_end) begin
                            state <= S_DONE;
                        end else if (addr_is_last) begin
                            state <= S_ERROR;
                        end else begin
                            delay_cnt <= DELAY_W'(entry_data) * UNIT_CYC;
                            rom_addr  <= rom_addr + ADDR_ONE;
                            state     <= S_DELAY;
                        end
                    end else if (bus_ready) begin
                        bus_reg   <= entry_reg;
                        bus_data  <= entry_data;
                        bus_start <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    timeout_cnt <= '0;
                    state       <= S_WAIT_ACK;
                end

                S_WAIT_ACK: begin
                    if (bus_done && !bus_nack) begin
                        retry_cnt <= '0;
                        if (addr_is_last) begin
                            state <= S_ERROR;
                        end else begin
                            rom_addr <= rom_addr + ADDR_ONE;
                            state    <= S_FETCH;
                        end
                    end else if (bus_done || (timeout_cnt == TMO_LAST)) begin
                        if (retry_cnt < RETRY_MAX) begin
                            retry_cnt <= retry_cnt + RETRY_ONE;
                            state     <= S_FETCH;
                        end else begin
                            state <= S_ERROR;
                        end
                    end else begin
                        timeout_cnt <= timeout_cnt + TMO_ONE;
                    end
                end

                S_DELAY: begin
                    if (delay_cnt <= DELAY_ONE) begin
                        delay_cnt <= '0;
                        state     <= S_FETCH;
                    end else begin
                        delay_cnt <= delay_cnt - DELAY_ONE;
                    end
                end

                S_DONE: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                end

                S_ERROR: begin
                    error    <= 1'b1;
                    err_addr <= rom_addr;
                    state    <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_config_seq.sv
// tb_sensor_config_seq
// Drives sensor_config_seq with a synchronous ROM model and a scripted bus
// responder. Each run's expected transaction list and outcome come from a
// per-entry walk of the ROM contents and the response plan.

module tb_sensor_config_seq;

    localparam int CLK_FREQ    = 2000000;
    localparam int ADDR_W      = 4;
    localparam int REG_W       = 8;
    localparam int DATA_W      = 8;
    localparam int MAX_RETRY   = 3;
    localparam int TIMEOUT_CYC = 40;
    localparam int DELAY_US    = 2;
    localparam int UNIT_CYC    = (CLK_FREQ / 1000000) * DELAY_US;
    localparam int ROM_DEPTH   = 1 << ADDR_W;
    localparam int PLAN_LEN    = 80;
    localparam int RESP_ACK    = 0;
    localparam int RESP_NACK   = 1;
    localparam int RESP_NONE   = 2;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    start = 1'b0;
    logic                    abort = 1'b0;
    logic [ADDR_W-1:0]       rom_addr;
    logic [REG_W+DATA_W-1:0] rom_data;
    logic                    bus_ready;
    logic                    bus_start;
    logic [REG_W-1:0]        bus_reg;
    logic [DATA_W-1:0]       bus_data;
    logic                    bus_done;
    logic                    bus_nack;
    logic                    busy;
    logic                    done;
    logic                    error;
    logic [ADDR_W-1:0]       err_addr;

    logic [15:0] rom_mem   [ROM_DEPTH];
    int          resp_plan [PLAN_LEN];
    int          lat_plan  [PLAN_LEN];
    logic [15:0] obs_log   [PLAN_LEN];
    logic [15:0] exp_log   [PLAN_LEN];

    logic resp_clear   = 1'b0;
    logic ready_always = 1'b1;
    int   obs_cnt;
    int   att_idx;
    int   countdown;
    logic pend_nack;
    int   start_total;

    int   checks = 0;
    int   errors = 0;
    int   first_addr;
    int   last_cycles;

    sensor_config_seq #(
        .CLK_FREQ    (CLK_FREQ),
        .ADDR_W      (ADDR_W),
        .REG_W       (REG_W),
        .DATA_W      (DATA_W),
        .MAX_RETRY   (MAX_RETRY),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .DELAY_US    (DELAY_US)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .bus_ready (bus_ready),
        .bus_start (bus_start),
        .bus_reg   (bus_reg),
        .bus_data  (bus_data),
        .bus_done  (bus_done),
        .bus_nack  (bus_nack),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .err_addr  (err_addr)
    );

    // 10-unit clock period.
    always #5 clk = ~clk;

    // Synchronous ROM: data follows the address one clock later.
    always @(posedge clk) begin
        rom_data <= rom_mem[rom_addr];
    end

    // Bus responder and monitor: logs each bus_start, then answers after the
    // planned latency with ACK or NACK, or stays silent to force a timeout.
    always @(negedge clk) begin
        bus_done = 1'b0;
        bus_nack = 1'b0;
        if (resp_clear) begin
            att_idx   = 0;
            countdown = 0;
            obs_cnt   = 0;
            pend_nack = 1'b0;
        end else if (bus_start) begin
            start_total++;
            if (obs_cnt < PLAN_LEN) begin
                obs_log[obs_cnt] = {bus_reg, bus_data};
                obs_cnt++;
            end
            if (att_idx >= PLAN_LEN) begin
                countdown = 3;
                pend_nack = 1'b0;
            end else if (resp_plan[att_idx] == RESP_NONE) begin
                countdown = 0;
            end else begin
                countdown = lat_plan[att_idx];
                pend_nack = (resp_plan[att_idx] == RESP_NACK);
            end
            att_idx++;
        end else if (countdown > 0) begin
            countdown--;
            if (countdown == 0) begin
                bus_done = 1'b1;
                bus_nack = pend_nack;
            end
        end
        bus_ready = ready_always ? 1'b1 : ($urandom_range(0, 3) != 0);
    end

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #900000;
        $display("[TB] FAIL watchdog: observed no completion, expected finish before 90000 cycles");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic clearResponder();
        resp_clear = 1'b1;
        @(negedge clk);
        #1;
        resp_clear = 1'b0;
    endtask

    task automatic fillRom(input logic [15:0] fill);
        for (int i = 0; i < ROM_DEPTH; i++) rom_mem[i] = fill;
    endtask

    task automatic setPlanAll(input int resp, input int lat);
        for (int i = 0; i < PLAN_LEN; i++) begin
            resp_plan[i] = resp;
            lat_plan[i]  = lat;
        end
    endtask

    task automatic kickStart();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Start a run and wait, bounded, until the block is idle with a result.
    task automatic applyStimulus(input int budget, output int cycles, output bit timed_out);
        kickStart();
        first_addr = int'(rom_addr);
        cycles     = 1;
        timed_out  = 1'b0;
        while (!(busy == 1'b0 && (done || error))) begin
            if (cycles >= budget) begin
                timed_out = 1'b1;
                break;
            end
            @(negedge clk);
            cycles++;
        end
    endtask

    // Reference: walk the ROM entry by entry, consuming one planned response
    // per write attempt, and record what should appear on the bus.
    task automatic modelRun(output int n_exp, output bit exp_done, output bit exp_err, output int exp_addr);
        int          addr;
        int          retry;
        int          k;
        int          resp;
        logic [15:0] e;
        addr     = 0;
        retry    = 0;
        k        = 0;
        n_exp    = 0;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        for (int step = 0; step < 400; step++) begin
            e = rom_mem[addr];
            if (e == 16'hFFFF) begin
                exp_done = 1'b1;
                break;
            end
            if (e[15:8] == 8'hFF) begin
                if (addr == ROM_DEPTH - 1) begin
                    exp_err = 1'b1;
                    break;
                end
                addr++;
                continue;
            end
            if (n_exp < PLAN_LEN) exp_log[n_exp] = e;
            n_exp++;
            resp = (k < PLAN_LEN) ? resp_plan[k] : RESP_ACK;
            k++;
            if (resp == RESP_ACK) begin
                retry = 0;
                if (addr == ROM_DEPTH - 1) begin
                    exp_err = 1'b1;
                    break;
                end
                addr++;
            end else if (retry < MAX_RETRY) begin
                retry++;
            end else begin
                exp_err = 1'b1;
                break;
            end
        end
        exp_addr = addr;
    endtask

    task automatic runScenario(input string tag, input int budget);
        int n_exp;
        bit exp_done;
        bit exp_err;
        int exp_addr;
        int cycles;
        bit tmo;
        modelRun(n_exp, exp_done, exp_err, exp_addr);
        clearResponder();
        applyStimulus(budget, cycles, tmo);
        last_cycles = cycles;
        checkOutput({tag, "_finished"}, tmo, 1'b0);
        checkOutput({tag, "_nstart"}, obs_cnt, n_exp);
        for (int i = 0; i < n_exp && i < obs_cnt && i < PLAN_LEN; i++)
            checkOutput($sformatf("%s_txn%0d", tag, i), obs_log[i], exp_log[i]);
        checkOutput({tag, "_done"}, done, exp_done);
        checkOutput({tag, "_error"}, error, exp_err);
        checkOutput({tag, "_rom_addr"}, rom_addr, exp_addr);
        if (exp_err) checkOutput({tag, "_err_addr"}, err_addr, exp_addr);
        checkOutput({tag, "_busy"}, busy, 1'b0);
        if (tmo) begin
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
        end
    endtask

    initial begin
        int          s0;
        int          n;
        int          r;
        int          d;
        int          waited;
        bit          overflow;
        int          delays [3];

        fillRom(16'hFFFF);
        setPlanAll(RESP_ACK, 3);
        repeat (3) @(negedge clk);

        // Reset state.
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_error", error, 1'b0);
        checkOutput("rst_rom_addr", rom_addr, 0);
        checkOutput("rst_err_addr", err_addr, 0);
        checkOutput("rst_bus_start", bus_start, 1'b0);
        checkOutput("rst_bus_reg", bus_reg, 0);
        checkOutput("rst_bus_data", bus_data, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Two writes then end marker, every write ACKed after 10 cycles.
        $display("[TB] basic two-write sequence");
        fillRom(16'hFFFF);
        rom_mem[0] = 16'h1280;
        rom_mem[1] = 16'h1100;
        setPlanAll(RESP_ACK, 10);
        runScenario("basic", 2000);
        checkOutput("basic_txn0_lit", obs_log[0], 16'h1280);
        checkOutput("basic_txn1_lit", obs_log[1], 16'h1100);
        checkOutput("basic_rom_addr_lit", rom_addr, 2);

        // Abort (with start also high) while idle keeps done and sends nothing.
        s0 = start_total;
        abort = 1'b1;
        start = 1'b1;
        repeat (2) @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checkOutput("idle_abort_busy", busy, 1'b0);
        checkOutput("idle_abort_done", done, 1'b1);
        checkOutput("idle_abort_nstart", start_total, s0);

        // Persistent NACK: one try plus MAX_RETRY retries, then error at 0.
        $display("[TB] persistent NACK");
        fillRom(16'hFFFF);
        rom_mem[0] = 16'h3A04;
        setPlanAll(RESP_NACK, 3);
        runScenario("nack", 2000);
        checkOutput("nack_nstart_lit", obs_cnt, 4);
        checkOutput("nack_error_lit", error, 1'b1);
        checkOutput("nack_err_addr_lit", err_addr, 0);
        checkOutput("nack_done_lit", done, 1'b0);

        // Bus never answers: four timeouts then error.
        $display("[TB] bus timeout");
        fillRom(16'hFFFF);
        rom_mem[0] = 16'h5566;
        setPlanAll(RESP_NONE, 3);
        runScenario("tmo", 1000);
        checkOutput($sformatf("tmo_window_cyc%0d", last_cycles),
                    (last_cycles >= 4 * TIMEOUT_CYC) && (last_cycles <= 4 * TIMEOUT_CYC + 40), 1'b1);

        // Pure delay entries: completion time tracks data * cycles-per-unit.
        $display("[TB] delay timing");
        delays = '{0, 1, 64};
        foreach (delays[j]) begin
            fillRom(16'hFFFF);
            rom_mem[0] = {8'hFF, 8'(delays[j])};
            setPlanAll(RESP_ACK, 3);
            runScenario($sformatf("delay%0d", delays[j]), 2000);
            d = delays[j] * UNIT_CYC;
            checkOutput($sformatf("delay%0d_window_cyc%0d", delays[j], last_cycles),
                        (last_cycles >= d) && (last_cycles <= d + 8), 1'b1);
        end

        // Abort in the middle of a delay, then restart from entry 0.
        $display("[TB] abort during delay");
        fillRom(16'hFFFF);
        rom_mem[0] = 16'hFF10;
        rom_mem[1] = 16'h1234;
        setPlanAll(RESP_ACK, 4);
        clearResponder();
        kickStart();
        repeat (10) @(negedge clk);
        checkOutput("abort_pre_busy", busy, 1'b1);
        s0 = start_total;
        abort = 1'b1;
        @(negedge clk);
        checkOutput("abort_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        abort = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("abort_nstart", start_total, s0);
        checkOutput("abort_done_kept", done, 1'b0);
        checkOutput("abort_error_kept", error, 1'b0);
        runScenario("abort_restart", 2000);
        checkOutput("abort_restart_addr0", first_addr, 0);

        // Asynchronous reset while waiting for the bus.
        $display("[TB] reset during wait");
        fillRom(16'hFFFF);
        rom_mem[0] = 16'h5566;
        setPlanAll(RESP_NONE, 3);
        clearResponder();
        kickStart();
        waited = 0;
        while (obs_cnt == 0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("arst_issue_seen", obs_cnt, 1);
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_busy", busy, 1'b0);
        checkOutput("arst_bus_start", bus_start, 1'b0);
        checkOutput("arst_bus_reg", bus_reg, 0);
        checkOutput("arst_bus_data", bus_data, 0);
        checkOutput("arst_rom_addr", rom_addr, 0);
        checkOutput("arst_error", error, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        s0 = start_total;
        repeat (60) @(negedge clk);
        checkOutput("arst_post_nstart", start_total, s0);
        checkOutput("arst_post_busy", busy, 1'b0);

        // No end marker: walking off the last address reports all-ones.
        $display("[TB] address overflow");
        for (int i = 0; i < ROM_DEPTH; i++) rom_mem[i] = {8'(i), 8'(i ^ 8'h5A)};
        setPlanAll(RESP_ACK, 2);
        runScenario("ovf", 3000);
        checkOutput("ovf_error_lit", error, 1'b1);
        checkOutput("ovf_err_addr_lit", err_addr, ROM_DEPTH - 1);

        // Randomized ROMs, response plans and bus_ready behaviour.
        $display("[TB] randomized sequences");
        ready_always = 1'b0;
        for (int s = 0; s < 25; s++) begin
            n        = $urandom_range(1, 15);
            overflow = ($urandom_range(0, 4) == 0);
            for (int i = 0; i < ROM_DEPTH; i++) begin
                if (!overflow && i == n)
                    rom_mem[i] = 16'hFFFF;
                else if ($urandom_range(0, 4) == 0)
                    rom_mem[i] = {8'hFF, 8'($urandom_range(0, 3))};
                else
                    rom_mem[i] = {8'($urandom_range(0, 254)), 8'($urandom)};
            end
            for (int i = 0; i < PLAN_LEN; i++) begin
                r = $urandom_range(0, 19);
                resp_plan[i] = (r < 14) ? RESP_ACK : ((r < 18) ? RESP_NACK : RESP_NONE);
                lat_plan[i]  = $urandom_range(1, 10);
            end
            runScenario($sformatf("rnd%0d", s), 8000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
